inst_cache: RTL and testbench
=============================

// Module: inst_cache
// PURPOSE
//  Direct-mapped, read-only instruction cache in front of the IF stage.
//  - Serves PC_IF fetches on hit in the same cycle.
//  - On miss, holds the pipeline via `miss` (hazard unit drives bubbleF/bubbleD).
//  - Fills the whole line from main memory, one word per req/gnt beat.
//  - Replaces the fixed instruction RAM as the source of inst_ID.
// PARAMETERS
//  LINE_ADDR_LEN  3   log2(words per line); 8 words
//  SET_ADDR_LEN   4   log2(sets); 16 lines
//  TAG_ADDR_LEN   derived = 30-LINE_ADDR_LEN-SET_ADDR_LEN; not overridable
// PORTS
//  clk         in   1   core clock, rising edge
//  rst         in   1   async reset, active-high
//  rd_req      in   1   fetch valid this cycle
//  addr        in   32  fetch byte address (PC_IF); [1:0] ignored
//  rd_data     out  32  instruction word; valid when rd_req && !miss
//  miss        out  1   stall request to hazard unit
//  invalidate  in   1   one-cycle pulse; clears all valid bits (fence.i)
//  mem_req     out  1   line-fill beat request
//  mem_addr    out  32  word-aligned beat address
//  mem_gnt     in   1   beat accepted; mem_rdata valid same cycle
//  mem_rdata   in   32  fill data
// BEHAVIOUR
//  Address split: tag = addr[31:2+L+S], set = addr[2+L+S-1:2+L], word = addr[2+L-1:2].
//  hit = rd_req && valid[set] && tag_arr[set]==tag (combinational).
//  rd_data = data_arr[set][word] (combinational); 0 when !hit.
//  FSM states: IDLE, FILL, DONE.
//   IDLE: rd_req && !hit -> latch line base (addr with word bits zeroed), beat=0; go FILL.
//   FILL: mem_req=1, mem_addr = base + 4*beat.
//    - Each cycle with mem_gnt: write mem_rdata to beat slot, beat++.
//    - On gnt of last beat (2^L-1): write tag, set valid; go DONE.
//    - No gnt: hold; gaps of any length are legal.
//   DONE: one cycle, mem_req=0; go IDLE. Line is readable from the next cycle.
//  miss = (IDLE && rd_req && !hit) || FILL || DONE. Never asserted when !rd_req in IDLE.
//  Miss latency with gnt every cycle: 2^L+2 cycles of miss; 10 for the default.
//  addr changes during FILL are ignored; the fill completes for the latched line.
//   The new addr is re-evaluated in IDLE.
//  Replacement: the fill overwrites the indexed line unconditionally.
//  invalidate: clears all valid bits at the clock edge.
//   - During FILL, the in-flight line is still installed valid on completion.
//   - Simultaneous with final-beat install: the install wins for that set.
//  Reset (any time, incl. mid-fill):
//   - state=IDLE, beat=0, all valid=0, mem_req=0, mem_addr=0.
//   - miss reflects IDLE; the first fetch after reset misses.
//   - data/tag arrays are not reset.
//  mem_gnt outside FILL is ignored.
// CONFIGURATION
//  ICACHE_STATS_EN defined:
//   - Adds outputs hit_cnt[31:0] and miss_cnt[31:0], both reset to 0.
//   - hit_cnt++ each IDLE cycle with rd_req && hit.
//   - miss_cnt++ on each IDLE->FILL transition.
//   - Both saturate at 32'hFFFF_FFFF.
//  Undefined: the ports and counters are absent; all other behaviour is identical.
// TESTING
//  1 Cold fetch addr=0x100, gnt every cycle, mem_rdata=beat addr -> mem_addr 0x100..0x11C;
//    miss high 10 cycles; then rd_data=0x100.
//  2 After fill, fetch 0x104..0x11C -> miss=0 each cycle; rd_data=address value; mem_req stays 0.
//  3 Fetch 0x300 (same set as 0x100), then 0x100 -> two full fills; second refetches 0x100..0x11C.
//  4 gnt asserted every 3rd cycle during fill -> 8 beats captured in order;
//    miss held until DONE+1; data correct.
//  5 rst pulse at beat 4 -> mem_req=0 same cycle; refetch 0x100 -> full 8-beat fill from beat 0.
//  6 invalidate after filling 0x100 -> next fetch 0x100 misses;
//    with ICACHE_STATS_EN, miss_cnt=2 and hit_cnt matches the hits issued.

Source files
------------

// File: rtl/inst_cache.sv
// rtl/inst_cache.sv - direct-mapped read-only instruction cache with line fill
//
// Purpose:
//   Direct-mapped, read-only instruction cache feeding the IF stage.
//   Fetches that hit are served combinationally in the same cycle. A miss
//   raises `miss` so the hazard unit stalls the front end. The cache then
//   fills the whole line from main memory, one word per req/gnt beat.
//
// Optional feature:
//   ICACHE_STATS_EN - adds the saturating hit_cnt/miss_cnt outputs.
//
// Ports:
//   clk         in   1   core clock, rising edge
//   rst         in   1   asynchronous reset, active-high
//   rd_req      in   1   fetch valid this cycle
//   addr        in   32  fetch byte address (PC_IF); [1:0] ignored
//   rd_data     out  32  instruction word; valid when rd_req && !miss
//   miss        out  1   stall request to the hazard unit
//   invalidate  in   1   one-cycle pulse that clears every valid bit (fence.i)
//   mem_req     out  1   line-fill beat request
//   mem_addr    out  32  word-aligned beat address
//   mem_gnt     in   1   beat accepted; mem_rdata is valid in the same cycle
//   mem_rdata   in   32  fill data
//   hit_cnt     out  32  (ICACHE_STATS_EN) IDLE cycles with a hit, saturating
//   miss_cnt    out  32  (ICACHE_STATS_EN) started line fills, saturating

module inst_cache #(
  parameter int LINE_ADDR_LEN = 3,
  parameter int SET_ADDR_LEN  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rd_req,
  input  logic [31:0] addr,
  output logic [31:0] rd_data,
  output logic        miss,
  input  logic        invalidate,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_gnt,
  input  logic [31:0] mem_rdata
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt
`endif
);

  localparam int TAG_ADDR_LEN = 30 - LINE_ADDR_LEN - SET_ADDR_LEN;
  localparam int LINE_WORDS   = 1 << LINE_ADDR_LEN;
  localparam int SETS         = 1 << SET_ADDR_LEN;
  localparam int TAG_LSB      = 2 + LINE_ADDR_LEN + SET_ADDR_LEN;
  localparam int SET_LSB      = 2 + LINE_ADDR_LEN;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } state_t;

  // Fetch address split.
  logic [TAG_ADDR_LEN-1:0]  req_tag;
  logic [SET_ADDR_LEN-1:0]  req_set;
  logic [LINE_ADDR_LEN-1:0] req_word;

  assign req_tag  = addr[31:TAG_LSB];
  assign req_set  = addr[TAG_LSB-1:SET_LSB];
  assign req_word = addr[SET_LSB-1:2];

  // Byte offset within a word is irrelevant for 32-bit instruction fetch.
  logic unused_byte_offset;
  assign unused_byte_offset = ^addr[1:0];

  // Storage. Only the valid bits are reset; tag and data contents are
  // meaningless while their valid bit is clear.
  logic [TAG_ADDR_LEN-1:0] tag_arr  [SETS];
  logic [31:0]             data_arr [SETS][LINE_WORDS];
  logic [SETS-1:0]         valid_q;

  // Fill-side registers.
  state_t                   state_q;
  logic [LINE_ADDR_LEN-1:0] beat_q;
  logic [TAG_ADDR_LEN-1:0]  fill_tag_q;
  logic [SET_ADDR_LEN-1:0]  fill_set_q;
  logic                     mem_req_q;
  logic [31:0]              mem_addr_q;

  logic hit;
  logic beat_last;
  logic fill_we;
  logic install;
  logic start_fill;

  assign hit        = rd_req && valid_q[req_set] && (tag_arr[req_set] == req_tag);
  assign rd_data    = hit ? data_arr[req_set][req_word] : 32'h0;

  assign beat_last  = &beat_q;
  assign fill_we    = (state_q == FILL) && mem_gnt;
  assign install    = fill_we && beat_last;
  assign start_fill = (state_q == IDLE) && rd_req && !hit;

  // Stall through the whole fill plus the DONE cycle, so the requester
  // retries in IDLE once the new line is readable.
  assign miss       = start_fill || (state_q != IDLE);

  assign mem_req    = mem_req_q;
  assign mem_addr   = mem_addr_q;

  // Fill controller. The line base and index are latched on entry to FILL,
  // so later changes on addr cannot redirect an in-flight fill.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      beat_q     <= '0;
      fill_tag_q <= '0;
      fill_set_q <= '0;
      mem_req_q  <= 1'b0;
      mem_addr_q <= 32'h0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_fill) begin
            state_q    <= FILL;
            beat_q     <= '0;
            fill_tag_q <= req_tag;
            fill_set_q <= req_set;
            mem_req_q  <= 1'b1;
            mem_addr_q <= {addr[31:SET_LSB], {SET_LSB{1'b0}}};
          end
        end
        FILL: begin
          if (mem_gnt) begin
            // beat_q wraps back to zero after the last beat.
            beat_q     <= beat_q + 1'b1;
            mem_addr_q <= mem_addr_q + 32'd4;
            if (beat_last) begin
              state_q   <= DONE;
              mem_req_q <= 1'b0;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q   <= IDLE;
          mem_req_q <= 1'b0;
        end
      endcase
    end
  end

  // Valid bits. The install is written after the flash clear so a line
  // completing in the same cycle as an invalidate still ends up valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
    end else begin
      if (invalidate) begin
        valid_q <= '0;
      end
      if (install) begin
        valid_q[fill_set_q] <= 1'b1;
      end
    end
  end

  // Tag and data arrays: write-only from the fill path, never reset.
  always_ff @(posedge clk) begin
    if (fill_we) begin
      data_arr[fill_set_q][beat_q] <= mem_rdata;
    end
    if (install) begin
      tag_arr[fill_set_q] <= fill_tag_q;
    end
  end

`ifdef ICACHE_STATS_EN
  logic [31:0] hit_cnt_q,  hit_cnt_d;
  logic [31:0] miss_cnt_q, miss_cnt_d;

  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if ((state_q == IDLE) && hit && (hit_cnt_q != 32'hFFFF_FFFF)) begin
      hit_cnt_d = hit_cnt_q + 32'd1;
    end
    if (start_fill && (miss_cnt_q != 32'hFFFF_FFFF)) begin
      miss_cnt_d = miss_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_cnt_q  <= 32'h0;
      miss_cnt_q <= 32'h0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
`endif

endmodule

// File: tb/tb_inst_cache.sv
// tb/tb_inst_cache.sv - scoreboard testbench for inst_cache
module tb_inst_cache;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rd_req = 1'b0;
  logic [31:0] addr = 32'h0;
  logic [31:0] rd_data;
  logic        miss;
  logic        invalidate = 1'b0;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt = 1'b0;
  logic [31:0] mem_rdata;
`ifdef ICACHE_STATS_EN
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;
`endif

  always #5 clk = ~clk;

  // Main memory returns the beat address as its data word.
  assign mem_rdata = mem_addr;

  inst_cache dut (
    .clk        (clk),
    .rst        (rst),
    .rd_req     (rd_req),
    .addr       (addr),
    .rd_data    (rd_data),
    .miss       (miss),
    .invalidate (invalidate),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_gnt    (mem_gnt),
    .mem_rdata  (mem_rdata)
`ifdef ICACHE_STATS_EN
    ,
    .hit_cnt    (hit_cnt),
    .miss_cnt   (miss_cnt)
`endif
  );

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_beat_q [$];
  logic [31:0] exp_data_q [$];

  int gnt_period = 1;
  int gnt_ctr    = 0;
  int hits_issued = 0;

  logic        miss_s;
  logic        mem_req_s;
  logic [31:0] rd_data_s;

  // One clock cycle: inputs are already set (at posedge+1). Outputs are
  // sampled at the falling edge; granted beats are checked against the
  // expected beat-address queue.
  task automatic tick();
    logic [31:0] exp;
    gnt_ctr++;
    mem_gnt = mem_req && ((gnt_ctr % gnt_period) == 0);
    @(negedge clk);
    if (mem_req && mem_gnt) begin
      checks++;
      if (exp_beat_q.size() == 0) begin
        errors++;
        $display("FAIL beat_addr: unexpected beat at mem_addr %h, none required", mem_addr);
      end else begin
        exp = exp_beat_q.pop_front();
        if (mem_addr !== exp) begin
          errors++;
          $display("FAIL beat_addr: got %h required %h", mem_addr, exp);
        end
      end
    end
    miss_s    = miss;
    mem_req_s = mem_req;
    rd_data_s = rd_data;
    @(posedge clk);
    #1;
  endtask

  // Fetch one word, waiting out any miss. exp_miss is the required number
  // of cycles with miss high; inv_at pulses invalidate on that cycle.
  task automatic fetch(input logic [31:0] a, input int exp_miss, input int inv_at);
    int  n;
    bit  got;
    logic [31:0] exp;
    rd_req  = 1'b1;
    addr    = a;
    gnt_ctr = 0;
    exp_data_q.push_back(a);
    if (exp_miss > 0) begin
      for (int i = 0; i < 8; i++) exp_beat_q.push_back({a[31:5], 5'b0} + 32'(4 * i));
    end
    n   = 0;
    got = 1'b0;
    for (int c = 0; c < 200; c++) begin
      invalidate = (c == inv_at);
      tick();
      if (!miss_s) begin
        got = 1'b1;
        break;
      end
      n++;
    end
    invalidate = 1'b0;
    rd_req     = 1'b0;
    exp = exp_data_q.pop_front();
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL fetch_timeout: addr %h still missing after %0d cycles, required hit", a, n);
    end else begin
      hits_issued++;
      if (rd_data_s !== exp) begin
        errors++;
        $display("FAIL rd_data: addr %h got %h required %h", a, rd_data_s, exp);
      end
    end
    checks++;
    if (n != exp_miss) begin
      errors++;
      $display("FAIL miss_cycles: addr %h got %0d required %0d", a, n, exp_miss);
    end
    checks++;
    if (exp_beat_q.size() != 0) begin
      errors++;
      $display("FAIL beats_left: addr %h got %0d outstanding required 0", a, exp_beat_q.size());
      exp_beat_q.delete();
    end
    if (exp_miss == 0) begin
      checks++;
      if (mem_req_s !== 1'b0) begin
        errors++;
        $display("FAIL hit_mem_req: addr %h got %b required 0", a, mem_req_s);
      end
    end
  endtask

  task automatic test_reset();
    #2 rst = 1'b1;
    #1;
    checks++;
    if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req: got %b required 0", mem_req); end
    checks++;
    if (mem_addr !== 32'h0) begin errors++; $display("FAIL reset_mem_addr: got %h required 0", mem_addr); end
    checks++;
    if (miss !== 1'b0) begin errors++; $display("FAIL reset_idle_miss: got %b required 0", miss); end
    rd_req = 1'b1;
    addr   = 32'h100;
    #1;
    checks++;
    if (miss !== 1'b1) begin errors++; $display("FAIL reset_cold_miss: got %b required 1", miss); end
    checks++;
    if (rd_data !== 32'h0) begin errors++; $display("FAIL reset_rd_data: got %h required 0", rd_data); end
    rd_req = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_cold_fill();
    fetch(32'h100, 10, -1);
  endtask

  task automatic test_line_hits();
    for (int i = 1; i < 8; i++) fetch(32'h100 + 32'(4 * i), 0, -1);
  endtask

  task automatic test_conflict();
    fetch(32'h300, 10, -1);
    fetch(32'h31C, 0, -1);
    fetch(32'h100, 10, -1);
    fetch(32'h110, 0, -1);
    fetch(32'h11C, 0, -1);
  endtask

  task automatic test_slow_gnt();
    fetch(32'h300, 10, -1);
    gnt_period = 3;
    fetch(32'h100, 25, -1);
    gnt_period = 1;
    for (int i = 1; i < 8; i += 3) fetch(32'h100 + 32'(4 * i), 0, -1);
  endtask

  task automatic test_reset_mid_fill();
    fetch(32'h300, 10, -1);
    rd_req  = 1'b1;
    addr    = 32'h100;
    gnt_ctr = 0;
    for (int i = 0; i < 8; i++) exp_beat_q.push_back(32'h100 + 32'(4 * i));
    for (int c = 0; c < 50 && exp_beat_q.size() > 4; c++) tick();
    checks++;
    if (exp_beat_q.size() != 4) begin
      errors++;
      $display("FAIL pre_reset_beats: got %0d outstanding required 4", exp_beat_q.size());
    end
    mem_gnt = 1'b0;
    rst     = 1'b1;
    #1;
    checks++;
    if (mem_req !== 1'b0) begin errors++; $display("FAIL midfill_mem_req: got %b required 0", mem_req); end
    checks++;
    if (mem_addr !== 32'h0) begin errors++; $display("FAIL midfill_mem_addr: got %h required 0", mem_addr); end
    exp_beat_q.delete();
    rd_req = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    fetch(32'h100, 10, -1);
    fetch(32'h300, 10, -1);
  endtask

  task automatic test_invalidate();
    rst = 1'b1;
    #1;
    @(posedge clk);
    #1 rst = 1'b0;
    hits_issued = 0;
    fetch(32'h100, 10, -1);
    fetch(32'h108, 0, -1);
    invalidate = 1'b1;
    tick();
    invalidate = 1'b0;
    fetch(32'h100, 10, -1);
`ifdef ICACHE_STATS_EN
    checks++;
    if (miss_cnt !== 32'd2) begin errors++; $display("FAIL miss_cnt: got %0d required 2", miss_cnt); end
    checks++;
    if (hit_cnt !== 32'(hits_issued)) begin
      errors++;
      $display("FAIL hit_cnt: got %0d required %0d", hit_cnt, hits_issued);
    end
`endif
    // Invalidate in the middle of a fill: the in-flight line still installs.
    fetch(32'h140, 10, 4);
    fetch(32'h144, 0, -1);
    fetch(32'h100, 10, -1);
    // Invalidate on the final-beat cycle: the install wins.
    fetch(32'h180, 10, 8);
    fetch(32'h19C, 0, -1);
  endtask

  initial begin
    test_reset();
    test_cold_fill();
    test_line_hits();
    test_conflict();
    test_slow_gnt();
    test_reset_mid_fill();
    test_invalidate();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
